// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared FSM encoding and default timing constants
// for the multiply issue controller.
package mul_ctrl_pkg;

    localparam int DEF_MUL_LATENCY    = 5;
    localparam int DEF_TIMEOUT_CYCLES = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/mul_timeout_ctr.sv
// mul_timeout_ctr: counts cycles while enabled, flags the last allowed one.
// Saturates so the flag holds until the enable drops.
module mul_timeout_ctr
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || !count_en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: single-entry multiply issue/writeback controller.
// Optional WAIT/DRAIN timeout enabled by MUL_ISSUE_TIMEOUT_EN.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY    = DEF_MUL_LATENCY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_a,
    input  logic [31:0]           req_b,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic                  flush,
    output logic [31:0]           mul_a_out,
    output logic [31:0]           mul_b_out,
    output logic                  mul_valid_out,
    input  logic                  mul_stall_in,
    input  logic [31:0]           mul_result_in,
    input  logic                  mul_valid_in,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [31:0]           wb_data,
    output logic                  busy_valid,
    output logic [REG_ADDR_W-1:0] busy_rd,
    output logic                  err_timeout
);

    if (MUL_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mul_issue_ctrl: latency and timeout must be positive");
    end

    state_t                state;
    state_t                state_nx;
    logic [31:0]           a_q;
    logic [31:0]           b_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [31:0]           data_q;
    logic                  accept;
    logic                  capture;
    logic                  timeout_hit;

    assign req_ready = (state == ST_IDLE);
    // flush wins over a same-cycle handshake
    assign accept    = req_valid && req_ready && !flush;
    assign capture   = (state == ST_WAIT) && mul_valid_in && !flush;

    assign mul_valid_out = (state == ST_ISSUE) && !mul_stall_in && !flush;
    assign mul_a_out     = mul_valid_out ? a_q : '0;
    assign mul_b_out     = mul_valid_out ? b_q : '0;

    assign wb_valid = (state == ST_WB) && !flush;
    assign wb_rd    = (state == ST_WB) ? rd_q : '0;
    assign wb_data  = (state == ST_WB) ? data_q : '0;

    assign busy_valid = (state == ST_ISSUE) || (state == ST_WAIT)
                     || (state == ST_WB);
    assign busy_rd    = busy_valid ? rd_q : '0;

`ifdef MUL_ISSUE_TIMEOUT_EN
    logic expired;
    logic counting;
    logic err_q;

    assign counting = (state == ST_WAIT) || (state == ST_DRAIN);

    mul_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset   (reset),
        .count_en(counting),
        .expired (expired)
    );

    // a flush on the last WAIT cycle still moves to DRAIN first
    assign timeout_hit = expired && !mul_valid_in
                      && !((state == ST_WAIT) && flush);

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (flush)             state_nx = ST_IDLE;
                else if (!mul_stall_in) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nx = mul_valid_in ? ST_IDLE : ST_DRAIN;
                end else if (mul_valid_in) begin
                    state_nx = (rd_q == '0) ? ST_IDLE : ST_WB;
                end else if (timeout_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WB: begin
                if (flush || wb_ready) state_nx = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mul_valid_in || timeout_hit) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q  <= req_a;
                b_q  <= req_b;
                rd_q <= req_rd;
            end
            if (capture) data_q <= mul_result_in;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed bench with a transaction-level scoreboard
// and a fixed-latency multiplier model.
module tb_mul_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic [31:0] mul_a_out;
    logic [31:0] mul_b_out;
    logic        mul_valid_out;
    logic        mul_stall_in;
    logic [31:0] mul_result_in;
    logic        mul_valid_in;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy_valid;
    logic [4:0]  busy_rd;
    logic        err_timeout;

    mul_issue_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_rd       (req_rd),
        .flush        (flush),
        .mul_a_out    (mul_a_out),
        .mul_b_out    (mul_b_out),
        .mul_valid_out(mul_valid_out),
        .mul_stall_in (mul_stall_in),
        .mul_result_in(mul_result_in),
        .mul_valid_in (mul_valid_in),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .busy_valid   (busy_valid),
        .busy_rd      (busy_rd),
        .err_timeout  (err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         exp_q[$];
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          checks;
    int          errors;
    int          pulses;
    int          pend;
    logic [31:0] prod;
    logic        never_ret;
    logic        inject;
    logic [31:0] inject_val;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // multiplier: result sampled 5 edges after the issue edge
    always @(negedge clock) begin
        mul_valid_in  = 1'b0;
        mul_result_in = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0 && !never_ret) begin
                mul_valid_in  = 1'b1;
                mul_result_in = prod;
            end
        end
        if (mul_valid_out) begin
            pulses++;
            pend = 5;
            prod = mul_a_out * mul_b_out;
        end
        if (inject) begin
            mul_valid_in  = 1'b1;
            mul_result_in = inject_val;
        end
    end

    // per-cycle scoreboard against the expected writeback stream
    always @(negedge clock) begin
        if (!mul_valid_out) begin
            chk("mul_a_zero", mul_a_out, 0);
            chk("mul_b_zero", mul_b_out, 0);
        end else begin
            chk("mul_a_op", mul_a_out, exp_a);
            chk("mul_b_op", mul_b_out, exp_b);
        end
        chk("ready_busy_excl", 64'(req_ready & busy_valid), 0);
        if (wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got rd %0d data %0h expected none",
                         wb_rd, wb_data);
            end else begin
                chk("wb_rd", wb_rd, exp_q[0].rd);
                chk("wb_data", wb_data, exp_q[0].data);
                if (wb_ready) void'(exp_q.pop_front());
            end
        end
`ifndef MUL_ISSUE_TIMEOUT_EN
        chk("err_tied", err_timeout, 0);
`endif
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit wb);
        wb_t e;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        exp_a     = a;
        exp_b     = b;
        if (wb) begin
            e.rd   = rd;
            e.data = a * b;
            exp_q.push_back(e);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (!wb_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mvo"}, mul_valid_out, 0);
        chk({tag, "_ma"}, mul_a_out, 0);
        chk({tag, "_mb"}, mul_b_out, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_wbrd"}, wb_rd, 0);
        chk({tag, "_wbd"}, wb_data, 0);
        chk({tag, "_busy"}, busy_valid, 0);
        chk({tag, "_busyrd"}, busy_rd, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        checks = 0; errors = 0; pulses = 0; pend = 0;
        never_ret = 1'b0; inject = 1'b0; inject_val = '0;
        prod = '0; exp_a = '0; exp_b = '0;
        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_rd = '0; flush = 1'b0; mul_stall_in = 1'b0; wb_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        reset_checks("por");

        // basic 6*7 -> x3
        p0 = pulses;
        accept(32'd6, 32'd7, 5'd3, 1);
        wait_wb(n);
        chk("basic_lat", n, 6);
        chk("basic_rd", wb_rd, 3);
        chk("basic_data", wb_data, 42);
        step();
        chk("basic_pulses", pulses - p0, 1);
        chk("basic_idle", req_ready, 1);
        chk("basic_q", exp_q.size(), 0);

        // issue stall for 3 cycles
        p0 = pulses;
        mul_stall_in = 1'b1;
        accept(32'hFFFF_FFFF, 32'd2, 5'd5, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", mul_valid_out, 0);
            chk("stall_busyrd", busy_rd, 5);
            step();
        end
        mul_stall_in = 1'b0;
        #1;
        chk("stall_issue", mul_valid_out, 1);
        wait_wb(n);
        chk("stall_lat", n, 6);
        chk("stall_data", wb_data, 32'hFFFF_FFFE);
        step();
        chk("stall_pulses", pulses - p0, 1);
        chk("stall_q", exp_q.size(), 0);

        // writeback backpressure
        wb_ready = 1'b0;
        accept(32'd3, 32'd5, 5'd7, 1);
        wait_wb(n);
        chk("bp_lat", n, 6);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", wb_valid, 1);
            chk("bp_rd", wb_rd, 7);
            chk("bp_data", wb_data, 15);
            chk("bp_ready", req_ready, 0);
            step();
        end
        wb_ready = 1'b1;
        step();
        chk("bp_done", wb_valid, 0);
        chk("bp_idle", req_ready, 1);
        chk("bp_q", exp_q.size(), 0);

        // rd == x0: no writeback
        p0 = pulses;
        accept(32'd9, 32'd9, 5'd0, 0);
        repeat (12) step();
        chk("x0_busy", busy_valid, 0);
        chk("x0_idle", req_ready, 1);
        chk("x0_pulses", pulses - p0, 1);

        // flush in WAIT -> DRAIN, late result dropped
        accept(32'd2, 32'd3, 5'd4, 0);
        step();
        chk("fl_wait_busy", busy_valid, 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_drain_busy", busy_valid, 0);
        chk("fl_drain_ready", req_ready, 0);
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        chk("fl_drain_len", n, 3);
        repeat (3) step();
        chk("fl_q", exp_q.size(), 0);

        // flush with a request in IDLE
        p0 = pulses;
        req_valid = 1'b1; req_a = 32'd11; req_b = 32'd13; req_rd = 5'd9;
        flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("flreq_ready", req_ready, 1);
        chk("flreq_busy", busy_valid, 0);
        repeat (8) step();
        chk("flreq_pulses", pulses - p0, 0);

        // multiplier that never answers
        never_ret = 1'b1;
        accept(32'd1, 32'd1, 5'd2, 0);
`ifdef MUL_ISSUE_TIMEOUT_EN
        n = 0;
        while (!err_timeout && n < 40) begin
            step();
            n++;
        end
        chk("to_lat", n, 9);
        chk("to_ready", req_ready, 1);
        step();
        chk("to_pulse", err_timeout, 0);
        chk("to_ready2", req_ready, 1);
        accept(32'd4, 32'd4, 5'd6, 0);
        repeat (3) step();
`else
        for (int i = 0; i < 20; i++) begin
            chk("nto_busy", busy_valid, 1);
            chk("nto_ready", req_ready, 0);
            step();
        end
`endif
        // reset while waiting, stale result ignored
        chk("rst_pre_busy", busy_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        reset_checks("rst");
        step();
        step();
        inject = 1'b1; inject_val = 32'hDEAD;
        step();
        inject = 1'b0;
        repeat (3) step();
        chk("rst_late_busy", busy_valid, 0);
        chk("rst_late_ready", req_ready, 1);
        chk("rst_q", exp_q.size(), 0);
        never_ret = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 5, the nominal issue-to-result cycles of the multiplier unit.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8, the WAIT/DRAIN cycles allowed before timeout.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, the destination register index width.
REQ-004 SHALL have ports, one per line:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  decode presents a multiply.
- req_ready  out  1  controller can accept.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_rd  in  REG_ADDR_W  destination register.
- flush  in  1  squash the in-flight multiply.
- mul_a_out  out  32  operand A to the multiplier.
- mul_b_out  out  32  operand B to the multiplier.
- mul_valid_out  out  1  one-cycle start pulse to the multiplier.
- mul_stall_in  in  1  multiplier busy.
- mul_result_in  in  32  multiplier result.
- mul_valid_in  in  1  multiplier result valid.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  register file accepts the writeback.
- wb_rd  out  REG_ADDR_W  writeback register.
- wb_data  out  32  writeback data.
- busy_valid  out  1  a destination register is pending.
- busy_rd  out  REG_ADDR_W  the pending register, used for decode hazard stall.
- err_timeout  out  1  one-cycle timeout pulse.

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT, WB and DRAIN.
REQ-006 SHALL drive req_ready=1 only in IDLE.
REQ-007 SHALL, on a cycle with req_valid&&req_ready, register req_a, req_b and req_rd and go to ISSUE.
REQ-008 SHALL, in ISSUE with mul_stall_in=0, drive mul_valid_out=1 with the registered operands and go to WAIT.
REQ-009 SHALL, in ISSUE with mul_stall_in=1, hold ISSUE with mul_valid_out=0.
REQ-010 SHALL pulse mul_valid_out for exactly one cycle per accepted request.
REQ-011 SHALL drive mul_a_out and mul_b_out to 0 whenever mul_valid_out=0.
REQ-012 SHALL, in WAIT on mul_valid_in=1, capture mul_result_in into wb_data and go to WB, or to IDLE with no writeback when rd==0.
REQ-013 SHALL hold wb_valid=1 with wb_rd and wb_data stable in WB until wb_ready=1, then go to IDLE.
REQ-014 SHALL give a minimum latency of 6 rising edges from the accepting edge to wb_valid=1.
REQ-015 SHALL drive busy_valid=1 and busy_rd equal to the registered rd in ISSUE, WAIT and WB, and busy_valid=0 in IDLE and DRAIN.
REQ-016 SHALL, on flush in ISSUE or WB, go to IDLE with no multiplier pulse and no writeback.
REQ-017 SHALL, on flush in WAIT, go to DRAIN.
REQ-018 SHALL, in DRAIN, discard the result on mul_valid_in=1 and then go to IDLE.
REQ-019 SHALL treat flush in IDLE as a no-op.
REQ-020 SHALL give flush priority over a req handshake in the same cycle, so that no request is accepted.
REQ-021 SHALL ignore mul_valid_in in IDLE, ISSUE and WB.
REQ-022 SHALL give flush priority over a simultaneous mul_valid_in in WAIT: go to IDLE and discard the result.

Reset
REQ-023 SHALL, on reset, force IDLE and set mul_valid_out, mul_a_out, mul_b_out, wb_valid, wb_rd, wb_data, busy_valid, busy_rd and err_timeout to 0; req_ready SHALL read 1 in the first cycle after reset.
REQ-024 SHALL, on reset mid-operation, drop any in-flight request and ignore its late result because the state is IDLE.

Configuration
REQ-025 SHALL, with MUL_ISSUE_TIMEOUT_EN defined, count cycles spent in WAIT or DRAIN; after TIMEOUT_CYCLES cycles with no mul_valid_in it SHALL pulse err_timeout for one cycle and go to IDLE; the counter SHALL clear on every entry to WAIT.
REQ-026 SHALL, without MUL_ISSUE_TIMEOUT_EN, have no counter, tie err_timeout to 0 and wait in WAIT/DRAIN indefinitely.

Structure
REQ-027 SHALL take the state enum and the default MUL_LATENCY/TIMEOUT_CYCLES constants from shared package mul_ctrl_pkg.
REQ-028 SHALL implement the timeout counter as sub-module mul_timeout_ctr, instantiated only under MUL_ISSUE_TIMEOUT_EN.

Verification
REQ-029 SHALL cover basic op: A=6, B=7, rd=3, multiplier model latency 5, wb_ready=1 -> wb_valid 6 edges after accept with wb_rd=3, wb_data=42; mul_valid_out pulsed once.
REQ-030 SHALL cover stall: mul_stall_in=1 for 3 cycles after accept -> mul_valid_out delayed 3 cycles; wb_data=A*B low 32 bits (0xFFFFFFFF*2 -> 0xFFFFFFFE).
REQ-031 SHALL cover backpressure and x0: wb_ready=0 for 4 cycles -> wb_valid/wb_rd/wb_data stable, req_ready=0; rd=0 -> no wb_valid, return to IDLE.
REQ-032 SHALL cover flush in WAIT: DRAIN, late result discarded, wb_valid never 1, busy_valid=0 from the next cycle; flush with req_valid in IDLE -> not accepted.
REQ-033 SHALL cover timeout (MUL_ISSUE_TIMEOUT_EN): multiplier model never returns -> err_timeout pulse after 8 WAIT cycles, req_ready=1 next cycle; without the macro -> stays in WAIT.
REQ-034 SHALL cover reset in WAIT: all outputs 0, req_ready=1; result arriving 2 cycles later -> ignored.
